aes_iter_encrypt: RTL
=====================

Name: aes_iter_encrypt

Overview:
- Iterative AES-128 encryption engine: one round per clock, with on-the-fly key expansion.
- Generalises the single final-round combinational block into a full sequential cipher.
  - Configurable round count.
  - Final round omits MixColumns.
  - Valid/ready handshakes on input and output.
- Sits between the block-level stimulus/host interface and the ciphertext sink. It is the top-level DUT for cipher-path verification.

Parameters:
- NR, 10, number of rounds executed after the initial AddRoundKey. Legal range 1..10; the Rcon table covers 10 entries. Values <10 give reduced-round debug mode.
- RW, 4, round-counter width. Must satisfy 2**RW > NR.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  plaintext/key valid.
- in_ready  out  1  engine can accept a block.
- pt  in  128  plaintext, byte 0 in bits [127:120], column-major state.
- key  in  128  cipher key, same byte order.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  sink accepts ciphertext.
- ct  out  128  ciphertext.
- busy  out  1  high in RUN or DONE.

Behaviour:
- States:
  - IDLE: in_ready=1.
  - RUN: round counter rnd runs 1..NR.
  - DONE: out_valid=1, holding the result.
- Reset (async, rst_n=0):
  - state=IDLE, rnd=0, state_reg=0, rk_reg=0.
  - in_ready=1 after reset release; out_valid=0, ct=0, busy=0.
  - Reset mid-RUN or mid-DONE discards the block; no partial output ever appears.
- Accept: in IDLE, when in_valid&&in_ready at an edge:
  - state_reg<=pt^key, rk_reg<=key, rnd<=1, go RUN.
  - in_ready drops the next cycle.
- RUN edge, per round:
  - next_rk = keyexp(rk_reg, Rcon[rnd]).
  - If rnd<NR: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ next_rk.
  - If rnd==NR: state_reg <= ShiftRows(SubBytes(state_reg)) ^ next_rk, and go DONE.
  - rk_reg<=next_rk; rnd<=rnd+1.
- Latency: out_valid rises exactly NR edges after the accept edge (10 for default).
- DONE: ct=state_reg, held stable while out_valid&&!out_ready (backpressure of unbounded length).
  - On out_valid&&out_ready: go IDLE, clear out_valid.
  - in_ready rises the following cycle; no same-cycle re-accept, so throughput is 1 block per NR+2 cycles minimum.
- Input signals are ignored outside IDLE. in_valid may stay high without effect.
- ct is driven from the register only, with no combinational path from inputs.
- Key expansion (AES-128):
  - w = RotWord then SubWord of the last word, XOR Rcon in the MSB byte.
  - Chained XOR across the 4 words.
  - Rcon = 01,02,04,08,10,20,40,80,1b,36.
- MixColumns over GF(2^8) with polynomial 0x11b.

Optional Feature:
- Macro: AES_ITER_KEY_OUT_EN.
- When defined:
  - Adds port key_out out 128, equal to the final round key (rk_reg).
  - Valid and stable whenever out_valid=1; 0 after reset.
- When undefined: port absent, and rk_reg is only used internally.

Decomposition:
- Package aes_pkg:
  - typedef logic [127:0] aes_block_t.
  - enum {IDLE,RUN,DONE} aes_iter_state_t.
  - constant array RCON[1:10].
  - SBOX constant table and functions xtime(), sub_word(), rot_word().
- One sub-module: aes_round_comb.
  - Inputs: state, round key, last_round flag.
  - Output: round result (SubBytes→ShiftRows→[MixColumns unless last]→AddRoundKey).
  - Key expansion stays in the top as a package function.

Test Plan:
- FIPS-197 App. B, exercising the optional key output:
  - Stimulus: key=2b7e151628aed2a6abf7158809cf4f3c, pt=3243f6a8885a308d313198a2e0370734, out_ready=1.
  - ct=3925841d02dc09fbdc118597196a0b32; out_valid exactly 10 edges after accept.
  - With AES_ITER_KEY_OUT_EN: key_out=d014f9a8c9ee2589e13f0cc8b6630ca6.
- FIPS-197 App. C.1:
  - Stimulus: key=000102030405060708090a0b0c0d0e0f, pt=00112233445566778899aabbccddeeff.
  - ct=69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid, and toggle pt/key/in_valid meanwhile.
  - ct stays stable; in_ready=0 throughout; completion on the first out_ready=1 edge; in_ready=1 the next cycle.
- Reset mid-RUN:
  - Stimulus: assert rst_n=0 at round 5, release, then send the App. B vector.
  - Immediately after assertion: out_valid=0, busy=0, in_ready=1.
  - The next block yields the correct ct with no stale output.
- Back-to-back:
  - Stimulus: in_valid held high with 2 vectors queued.
  - Second accept occurs 1 cycle after the first handshake; both ct values are correct and in order.
- NR=1 build:
  - Stimulus: key=0, pt=0.
  - ct=ShiftRows(SubBytes(00…)) ^ roundkey1 = 62636363626363636263636362636363 ^ 63636363… = 01000000010000000100000001000000; latency 1 edge.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte/word helpers for the iterative cipher.
package aes_pkg;

    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_iter_state_t;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b sits at bit offset (255-b)*8, i.e. {~b, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // One AES-128 key-schedule step: next round key from the current one.
    function automatic aes_block_t key_expand(input aes_block_t rk, input logic [7:0] rcon);
        logic [31:0] t, w0, w1, w2, w3;
        t  = sub_word(rot_word(rk[31:0])) ^ {rcon, 24'h000000};
        w0 = rk[127:96] ^ t;
        w1 = rk[95:64]  ^ w0;
        w2 = rk[63:32]  ^ w1;
        w3 = rk[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic [127:0] result
);

    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;

    // Byte i of the block lives at bits [8*(15-i) +: 8]; index = row + 4*column.
    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign sb[8*(15-i) +: 8] = sbox(state[8*(15-i) +: 8]);
    end

    // Row r rotates left by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_shift_col
        for (genvar r = 0; r < 4; r++) begin : g_shift_row
            assign sr[8*(15-(r+4*c)) +: 8] = sb[8*(15-(r+4*((c+r)%4))) +: 8];
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        logic [7:0] a0, a1, a2, a3;
        assign a0 = sr[8*(15-4*c)     +: 8];
        assign a1 = sr[8*(15-(4*c+1)) +: 8];
        assign a2 = sr[8*(15-(4*c+2)) +: 8];
        assign a3 = sr[8*(15-(4*c+3)) +: 8];
        assign mc[8*(15-4*c)     +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign mc[8*(15-(4*c+1)) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign mc[8*(15-(4*c+2)) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign mc[8*(15-(4*c+3)) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

    assign result = (last_round ? sr : mc) ^ round_key;

endmodule

// File: rtl/aes_iter_encrypt.sv
// Iterative AES-128 encryptor, one round per clock with on-the-fly key expansion.
// Optional macro AES_ITER_KEY_OUT_EN exposes the final round key on key_out.
module aes_iter_encrypt
    import aes_pkg::*;
#(
    parameter int unsigned NR = 10,
    parameter int unsigned RW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] pt,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct,
    output logic         busy
`ifdef AES_ITER_KEY_OUT_EN
    ,
    output logic [127:0] key_out
`endif
);

    aes_iter_state_t state, state_next;
    logic [RW-1:0]   rnd;
    aes_block_t      state_reg;
    aes_block_t      rk_reg;
    aes_block_t      ct_q;
    aes_block_t      next_rk_c;
    aes_block_t      round_res_c;
    logic [7:0]      rcon_c;
    logic            last_c;
    logic            in_ready_d, out_valid_d, busy_d;

    assign last_c = (rnd == RW'(NR));

    // Round constant for the current round number.
    always_comb begin
        rcon_c = RCON[1];
        for (int unsigned i = 1; i <= NR; i++) begin
            if (rnd == RW'(i)) rcon_c = RCON[i];
        end
    end

    assign next_rk_c = key_expand(rk_reg, rcon_c);

    aes_round_comb u_round (
        .state      (state_reg),
        .round_key  (next_rk_c),
        .last_round (last_c),
        .result     (round_res_c)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_c)    state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the upcoming state, then registered.
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state_next)
            IDLE:    in_ready_d  = 1'b1;
            RUN:     busy_d      = 1'b1;
            DONE: begin
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            default: in_ready_d  = 1'b1;
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

    // Cipher datapath: load on accept, one round per RUN cycle, capture result on the last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd       <= '0;
            state_reg <= '0;
            rk_reg    <= '0;
            ct_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= pt ^ key;
                        rk_reg    <= key;
                        rnd       <= RW'(1);
                    end
                end
                RUN: begin
                    state_reg <= round_res_c;
                    rk_reg    <= next_rk_c;
                    rnd       <= rnd + RW'(1);
                    if (last_c) ct_q <= round_res_c;
                end
                default: ;
            endcase
        end
    end

    assign ct = ct_q;

`ifdef AES_ITER_KEY_OUT_EN
    assign key_out = rk_reg;
`endif

endmodule
